// File: rtl/alu_pipe_if.sv
// Execution-stage ALU bus: issue-side op/operands/tag plus the
// result-side valid/ready handshake toward write-back.
interface alu_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 7
);
    logic             valid_i;
    logic             ready_o;
    logic [4:0]       op_i;
    logic             word_i;
    logic             uw_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  valid_i, op_i, word_i, uw_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
        output ready_o, valid_o, result_o, tag_o
    );

    modport master (
        output valid_i, op_i, word_i, uw_i, rs1_i, rs2_i, tag_i, flush_i, ready_i,
        input  ready_o, valid_o, result_o, tag_o
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer ALU (base ops + Zbb subset) with an elastic
// valid/ready pipeline, bubble collapsing and flush. The result is
// computed combinationally ahead of stage 0; later stages only carry it.
module alu_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_pipe_if.slave  bus
);
    localparam int SW   = $clog2(XLEN);
    localparam bit RV64 = (XLEN == 64);

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_SLL    = 5'd2,  OP_SRL   = 5'd3,
        OP_SRA    = 5'd4,  OP_SLT    = 5'd5,  OP_SLTU   = 5'd6,  OP_AND   = 5'd7,
        OP_OR     = 5'd8,  OP_XOR    = 5'd9,  OP_XNOR   = 5'd10, OP_ANDN  = 5'd11,
        OP_ORN    = 5'd12, OP_ROL    = 5'd13, OP_ROR    = 5'd14, OP_SH1ADD = 5'd15,
        OP_SH2ADD = 5'd16, OP_SH3ADD = 5'd17, OP_MIN    = 5'd18, OP_MAX   = 5'd19,
        OP_MINU   = 5'd20, OP_MAXU   = 5'd21, OP_CLZ    = 5'd22, OP_CTZ   = 5'd23,
        OP_CPOP   = 5'd24, OP_SEXTB  = 5'd25, OP_SEXTH  = 5'd26, OP_ZEXTH = 5'd27
    } op_e;

    // Leading zeros within the low n bits; all-zero input yields n.
    function automatic logic [6:0] clz_f(input logic [63:0] v, input int n);
        logic [6:0] c;
        logic       hit;
        c   = '0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < n && !hit) begin
                if (v[i]) hit = 1'b1;
                else      c = c + 7'd1;
            end
        end
        return c;
    endfunction

    // Trailing zeros within the low n bits; all-zero input yields n.
    function automatic logic [6:0] ctz_f(input logic [63:0] v, input int n);
        logic [6:0] c;
        logic       hit;
        c   = '0;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < n && !hit) begin
                if (v[i]) hit = 1'b1;
                else      c = c + 7'd1;
            end
        end
        return c;
    endfunction

    // Population count; callers pass an already zero-extended operand.
    function automatic logic [6:0] cpop_f(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
        return c;
    endfunction

    logic                     word, uw;
    logic [XLEN-1:0]          a, b, a_uw;
    logic signed [XLEN-1:0]   s1, s2;
    logic [31:0]              a32, b32;
    logic signed [31:0]       s1_32;
    logic [SW-1:0]            sh;
    logic [4:0]               sh_w;
    logic [2*XLEN-1:0]        rol_d, ror_d;
    logic [63:0]              rolw_d, rorw_d;
    logic [XLEN-1:0]          full_res, alu_res;
    logic [31:0]              w32_res;
    logic                     word_op;

    // W-form and .uw only exist on the 64-bit datapath.
    assign word   = RV64 && bus.word_i;
    assign uw     = RV64 && bus.uw_i;
    assign a      = bus.rs1_i;
    assign b      = bus.rs2_i;
    assign a_uw   = uw ? XLEN'(bus.rs1_i[31:0]) : bus.rs1_i;
    assign s1     = bus.rs1_i;
    assign s2     = bus.rs2_i;
    assign a32    = bus.rs1_i[31:0];
    assign b32    = bus.rs2_i[31:0];
    assign s1_32  = bus.rs1_i[31:0];
    assign sh     = bus.rs2_i[SW-1:0];
    assign sh_w   = bus.rs2_i[4:0];
    // Rotates as shifts of the operand concatenated with itself.
    assign rol_d  = {a, a} << sh;
    assign ror_d  = {a, a} >> sh;
    assign rolw_d = {a32, a32} << sh_w;
    assign rorw_d = {a32, a32} >> sh_w;

    // Operation decode: full-width result plus a 32-bit W-form result.
    always_comb begin
        full_res = '0;
        w32_res  = '0;
        word_op  = 1'b0;
        case (op_e'(bus.op_i))
            OP_ADD:    begin full_res = a_uw + b;  w32_res = a32 + b32;     word_op = 1'b1; end
            OP_SUB:    begin full_res = a - b;     w32_res = a32 - b32;     word_op = 1'b1; end
            OP_SLL:    begin full_res = a_uw << sh; w32_res = a32 << sh_w;  word_op = 1'b1; end
            OP_SRL:    begin full_res = a >> sh;   w32_res = a32 >> sh_w;   word_op = 1'b1; end
            OP_SRA:    begin full_res = s1 >>> sh; w32_res = s1_32 >>> sh_w; word_op = 1'b1; end
            OP_SLT:    full_res = XLEN'(s1 < s2);
            OP_SLTU:   full_res = XLEN'(a < b);
            OP_AND:    full_res = a & b;
            OP_OR:     full_res = a | b;
            OP_XOR:    full_res = a ^ b;
            OP_XNOR:   full_res = ~(a ^ b);
            OP_ANDN:   full_res = a & ~b;
            OP_ORN:    full_res = a | ~b;
            OP_ROL:    begin full_res = rol_d[2*XLEN-1:XLEN]; w32_res = rolw_d[63:32]; word_op = 1'b1; end
            OP_ROR:    begin full_res = ror_d[XLEN-1:0];      w32_res = rorw_d[31:0];  word_op = 1'b1; end
            OP_SH1ADD: full_res = (a_uw << 1) + b;
            OP_SH2ADD: full_res = (a_uw << 2) + b;
            OP_SH3ADD: full_res = (a_uw << 3) + b;
            OP_MIN:    full_res = (s1 < s2) ? a : b;
            OP_MAX:    full_res = (s1 < s2) ? b : a;
            OP_MINU:   full_res = (a < b) ? a : b;
            OP_MAXU:   full_res = (a < b) ? b : a;
            OP_CLZ:    begin full_res = XLEN'(clz_f(64'(a), XLEN)); w32_res = 32'(clz_f(64'(a32), 32)); word_op = 1'b1; end
            OP_CTZ:    begin full_res = XLEN'(ctz_f(64'(a), XLEN)); w32_res = 32'(ctz_f(64'(a32), 32)); word_op = 1'b1; end
            OP_CPOP:   begin full_res = XLEN'(cpop_f(64'(a)));     w32_res = 32'(cpop_f(64'(a32)));     word_op = 1'b1; end
            OP_SEXTB:  full_res = XLEN'($signed(a[7:0]));
            OP_SEXTH:  full_res = XLEN'($signed(a[15:0]));
            OP_ZEXTH:  full_res = XLEN'(a[15:0]);
            default:   full_res = '0;
        endcase
    end

    // W-form results are sign-extended from bit 31.
    assign alu_res = (word && word_op) ? XLEN'($signed(w32_res)) : full_res;

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] adv_p;
    logic [STAGES-1:0] en_p;
    logic [XLEN-1:0]   res_p [STAGES];
    logic [TAG_W-1:0]  tag_p [STAGES];

    // A stage drains if downstream accepts or any later stage holds a bubble.
    always_comb begin
        logic a_tmp;
        adv_p = '0;
        en_p  = '0;
        for (int k = 0; k < STAGES; k++) begin
            a_tmp = bus.ready_i;
            for (int j = k + 1; j < STAGES; j++) a_tmp = a_tmp | ~vld_p[j];
            adv_p[k] = a_tmp;
            en_p[k]  = ~vld_p[k] | a_tmp;
        end
    end

    // Valid bits: reset and flush clear every stage; otherwise shift when enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            vld_p <= '0;
        end else begin
            if (en_p[0]) vld_p[0] <= bus.valid_i;
            for (int k = 1; k < STAGES; k++) begin
                if (en_p[k]) vld_p[k] <= vld_p[k-1];
            end
        end
    end

    // Result/tag carry registers; only load when real data arrives.
    always_ff @(posedge clk_i) begin
        // stage 0: capture computed result
        if (en_p[0] && bus.valid_i) begin
            res_p[0] <= alu_res;
            tag_p[0] <= bus.tag_i;
        end
        // stages 1..STAGES-1: pure carry
        for (int k = 1; k < STAGES; k++) begin
            if (en_p[k] && vld_p[k-1]) begin
                res_p[k] <= res_p[k-1];
                tag_p[k] <= tag_p[k-1];
            end
        end
    end

    assign bus.ready_o  = en_p[0];
    assign bus.valid_o  = vld_p[STAGES-1];
    assign bus.result_o = res_p[STAGES-1];
    assign bus.tag_o    = tag_p[STAGES-1];
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances (64/2, 32/1, 64/4) sharing operand
// drive, directed vector table plus backpressure, flush and reset sequences.
module tb_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  vin, rin;
    logic        fl;
    logic [4:0]  op;
    logic        w, uw;
    logic [63:0] a, b;
    logic [6:0]  tg;

    logic [2:0]  ov, ordy;
    logic [63:0] ores [3];
    logic [6:0]  otag [3];

    int checks = 0;
    int errors = 0;
    int stg [3] = '{2, 1, 4};

    alu_pipe_if #(.XLEN(64), .TAG_W(7)) bus0 ();
    alu_pipe_if #(.XLEN(32), .TAG_W(7)) bus1 ();
    alu_pipe_if #(.XLEN(64), .TAG_W(7)) bus2 ();

    assign bus0.valid_i = vin[0]; assign bus0.ready_i = rin[0]; assign bus0.op_i = op;
    assign bus0.word_i = w; assign bus0.uw_i = uw; assign bus0.rs1_i = a; assign bus0.rs2_i = b;
    assign bus0.tag_i = tg; assign bus0.flush_i = fl;
    assign bus1.valid_i = vin[1]; assign bus1.ready_i = rin[1]; assign bus1.op_i = op;
    assign bus1.word_i = w; assign bus1.uw_i = uw; assign bus1.rs1_i = a[31:0]; assign bus1.rs2_i = b[31:0];
    assign bus1.tag_i = tg; assign bus1.flush_i = fl;
    assign bus2.valid_i = vin[2]; assign bus2.ready_i = rin[2]; assign bus2.op_i = op;
    assign bus2.word_i = w; assign bus2.uw_i = uw; assign bus2.rs1_i = a; assign bus2.rs2_i = b;
    assign bus2.tag_i = tg; assign bus2.flush_i = fl;

    assign ov[0] = bus0.valid_o; assign ordy[0] = bus0.ready_o; assign ores[0] = bus0.result_o; assign otag[0] = bus0.tag_o;
    assign ov[1] = bus1.valid_o; assign ordy[1] = bus1.ready_o; assign ores[1] = {32'b0, bus1.result_o}; assign otag[1] = bus1.tag_o;
    assign ov[2] = bus2.valid_o; assign ordy[2] = bus2.ready_o; assign ores[2] = bus2.result_o; assign otag[2] = bus2.tag_o;

    alu_pipe #(.XLEN(64), .STAGES(2), .TAG_W(7)) u0 (.clk_i(clk), .rst_i(rst), .bus(bus0));
    alu_pipe #(.XLEN(32), .STAGES(1), .TAG_W(7)) u1 (.clk_i(clk), .rst_i(rst), .bus(bus1));
    alu_pipe #(.XLEN(64), .STAGES(4), .TAG_W(7)) u2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    typedef struct {
        int          d;
        logic [4:0]  op;
        logic        w;
        logic        uw;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tv [$];

    task automatic add_v(input int d, input logic [4:0] o, input logic ww, input logic uu,
                         input logic [63:0] x, input logic [63:0] y, input logic [63:0] e);
        vec_t v;
        v.d = d; v.op = o; v.w = ww; v.uw = uu; v.a = x; v.b = y; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input int d, input logic [4:0] o, input logic [63:0] x,
                            input logic [63:0] y, input int t);
        op = o; w = 1'b0; uw = 1'b0; a = x; b = y; tg = 7'(t); vin[d] = 1'b1;
    endtask

    // Stream one instance's vectors back to back; results appear STAGES cycles later.
    task automatic run_vecs(input int d);
        vec_t q [$];
        int   s;
        s = stg[d];
        foreach (tv[i]) if (tv[i].d == d) q.push_back(tv[i]);
        rin[d] = 1'b1;
        for (int c = 0; c < q.size() + s; c++) begin
            @(negedge clk);
            if (c < q.size()) begin
                op = q[c].op; w = q[c].w; uw = q[c].uw; a = q[c].a; b = q[c].b;
                tg = 7'(c); vin[d] = 1'b1;
            end else begin
                vin[d] = 1'b0;
            end
            #1;
            if (c >= s) begin
                chk($sformatf("d%0d.vec%0d.valid", d, c - s), 64'(ov[d]), 64'd1);
                chk($sformatf("d%0d.vec%0d.result", d, c - s), ores[d], q[c - s].exp);
                chk($sformatf("d%0d.vec%0d.tag", d, c - s), 64'(otag[d]), 64'(c - s));
            end
        end
    endtask

    // Fill with downstream stalled, then release; order and count must hold.
    task automatic run_bp(input int d);
        int s, n, issued, got;
        s = stg[d]; n = s + 3; issued = 0; got = 0;
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge clk);
            rin[d] = (c >= s + 2);
            if (issued < n) drive_op(d, 5'd0, 64'(issued), 64'd100, issued);
            else            vin[d] = 1'b0;
            #1;
            if (c == s || c == s + 1) begin
                chk($sformatf("d%0d.bp.ready_low", d), 64'(ordy[d]), 64'd0);
                chk($sformatf("d%0d.bp.hold_valid", d), 64'(ov[d]), 64'd1);
                chk($sformatf("d%0d.bp.hold_tag", d), 64'(otag[d]), 64'd0);
                chk($sformatf("d%0d.bp.hold_result", d), ores[d], 64'd100);
            end
            if (c == s + 2) chk($sformatf("d%0d.bp.full_ready", d), 64'(ordy[d]), 64'd1);
            if (vin[d] && ordy[d]) issued++;
            if (ov[d] && rin[d]) begin
                chk($sformatf("d%0d.bp.tag%0d", d, got), 64'(otag[d]), 64'(got));
                chk($sformatf("d%0d.bp.res%0d", d, got), ores[d], 64'(100 + got));
                got++;
            end
        end
        @(negedge clk);
        vin[d] = 1'b0;
        #1;
        chk($sformatf("d%0d.bp.count", d), 64'(got), 64'(n));
        chk($sformatf("d%0d.bp.drained", d), 64'(ov[d]), 64'd0);
    endtask

    // Flush with ops in flight plus one presented; next op keeps normal latency.
    task automatic run_flush(input int d);
        int s;
        s = stg[d];
        rin[d] = 1'b1;
        @(negedge clk); drive_op(d, 5'd0, 64'd1, 64'd1, 1);
        @(negedge clk); drive_op(d, 5'd0, 64'd2, 64'd2, 2);
        @(negedge clk); drive_op(d, 5'd0, 64'd3, 64'd3, 3); fl = 1'b1;
        @(negedge clk); fl = 1'b0; drive_op(d, 5'd0, 64'd5, 64'd6, 4);
        #1;
        chk($sformatf("d%0d.flush.valid_off", d), 64'(ov[d]), 64'd0);
        for (int c = 1; c <= s; c++) begin
            @(negedge clk);
            vin[d] = 1'b0;
            #1;
            if (c < s) begin
                chk($sformatf("d%0d.flush.bubble", d), 64'(ov[d]), 64'd0);
            end else begin
                chk($sformatf("d%0d.flush.next_valid", d), 64'(ov[d]), 64'd1);
                chk($sformatf("d%0d.flush.next_tag", d), 64'(otag[d]), 64'd4);
                chk($sformatf("d%0d.flush.next_result", d), ores[d], 64'd11);
            end
        end
    endtask

    // Reset with a full stalled pipe and an op presented during reset.
    task automatic run_reset(input int d);
        int s;
        s = stg[d];
        rin[d] = 1'b0;
        for (int c = 0; c < s; c++) begin
            @(negedge clk); drive_op(d, 5'd0, 64'(c), 64'd0, 10 + c);
        end
        @(negedge clk);
        drive_op(d, 5'd0, 64'd7, 64'd7, 20);
        #1;
        chk($sformatf("d%0d.rst.full_ready", d), 64'(ordy[d]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vin[d] = 1'b0;
        #1;
        chk($sformatf("d%0d.rst.valid", d), 64'(ov[d]), 64'd0);
        chk($sformatf("d%0d.rst.ready", d), 64'(ordy[d]), 64'd1);
        rin[d] = 1'b1;
        for (int c = 0; c < s; c++) begin
            @(negedge clk); #1;
            chk($sformatf("d%0d.rst.no_ghost", d), 64'(ov[d]), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; vin = '0; rin = '0; fl = 1'b0; op = '0; w = 1'b0; uw = 1'b0;
        a = '0; b = '0; tg = '0;

        // XLEN=64, STAGES=2
        add_v(0, 5'd0,  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
        add_v(0, 5'd0,  1, 0, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000);
        add_v(0, 5'd4,  1, 0, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000);
        add_v(0, 5'd16, 0, 1, 64'hFFFF_FFFF_0000_0001, 64'd2, 64'd6);
        add_v(0, 5'd22, 0, 0, 64'h0, 64'h0, 64'd64);
        add_v(0, 5'd22, 1, 0, 64'h1, 64'h0, 64'd31);
        add_v(0, 5'd23, 0, 0, 64'h100, 64'h0, 64'd8);
        add_v(0, 5'd24, 0, 0, 64'hF0F0, 64'h0, 64'd8);
        add_v(0, 5'd18, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_v(0, 5'd20, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        add_v(0, 5'd14, 0, 0, 64'h1, 64'd1, 64'h8000_0000_0000_0000);
        add_v(0, 5'd1,  0, 0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_v(0, 5'd2,  0, 0, 64'h1, 64'd67, 64'd8);
        add_v(0, 5'd3,  0, 0, 64'h8000_0000_0000_0000, 64'd63, 64'd1);
        add_v(0, 5'd5,  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        add_v(0, 5'd6,  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        add_v(0, 5'd7,  0, 0, 64'hF0F0, 64'hFF00, 64'hF000);
        add_v(0, 5'd8,  0, 0, 64'hF0F0, 64'hFF00, 64'hFFF0);
        add_v(0, 5'd9,  0, 0, 64'hF0F0, 64'hFF00, 64'h0FF0);
        add_v(0, 5'd10, 0, 0, 64'hF0, 64'hFF, 64'hFFFF_FFFF_FFFF_FFF0);
        add_v(0, 5'd11, 0, 0, 64'hFF, 64'h0F, 64'hF0);
        add_v(0, 5'd12, 0, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_v(0, 5'd13, 0, 0, 64'h8000_0000_0000_0001, 64'd1, 64'd3);
        add_v(0, 5'd14, 1, 0, 64'h1, 64'd1, 64'hFFFF_FFFF_8000_0000);
        add_v(0, 5'd15, 0, 0, 64'd3, 64'd4, 64'd10);
        add_v(0, 5'd17, 0, 0, 64'd1, 64'd1, 64'd9);
        add_v(0, 5'd19, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        add_v(0, 5'd21, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_v(0, 5'd23, 0, 0, 64'h0, 64'h0, 64'd64);
        add_v(0, 5'd23, 1, 0, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'd32);
        add_v(0, 5'd24, 1, 0, 64'hFFFF_FFFF_0000_000F, 64'h0, 64'd4);
        add_v(0, 5'd25, 0, 0, 64'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
        add_v(0, 5'd26, 0, 0, 64'h7FFF, 64'h0, 64'h7FFF);
        add_v(0, 5'd27, 0, 0, 64'hFFFF_FFFF_FFFF_8000, 64'h0, 64'h8000);
        add_v(0, 5'd28, 0, 0, 64'h1234, 64'h5678, 64'h0);
        add_v(0, 5'd0,  0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h1_0000_0000);
        add_v(0, 5'd2,  1, 0, 64'h1, 64'd31, 64'hFFFF_FFFF_8000_0000);
        add_v(0, 5'd3,  1, 0, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'd1);
        add_v(0, 5'd1,  1, 0, 64'h0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_v(0, 5'd7,  1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0000);
        // XLEN=32, STAGES=1 (word_i/uw_i ignored)
        add_v(1, 5'd0,  1, 0, 64'hFFFF_FFFF, 64'd1, 64'h0);
        add_v(1, 5'd22, 0, 0, 64'h0, 64'h0, 64'd32);
        add_v(1, 5'd14, 0, 0, 64'h1, 64'd1, 64'h8000_0000);
        add_v(1, 5'd4,  1, 0, 64'h8000_0000, 64'd4, 64'hF800_0000);
        add_v(1, 5'd16, 0, 1, 64'h1, 64'd2, 64'd6);
        add_v(1, 5'd23, 0, 0, 64'h0, 64'h0, 64'd32);
        add_v(1, 5'd2,  0, 0, 64'h1, 64'd33, 64'd2);
        add_v(1, 5'd18, 0, 0, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF);
        // XLEN=64, STAGES=4
        add_v(2, 5'd0,  0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0);
        add_v(2, 5'd14, 0, 0, 64'h1, 64'd1, 64'h8000_0000_0000_0000);
        add_v(2, 5'd22, 1, 0, 64'h1, 64'h0, 64'd31);
        add_v(2, 5'd20, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
        add_v(2, 5'd24, 0, 0, 64'hF0F0, 64'h0, 64'd8);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d.reset.valid", d), 64'(ov[d]), 64'd0);
            chk($sformatf("d%0d.reset.ready", d), 64'(ordy[d]), 64'd1);
        end

        for (int d = 0; d < 3; d++) run_vecs(d);
        for (int d = 0; d < 3; d++) run_bp(d);
        for (int d = 0; d < 3; d++) run_flush(d);
        for (int d = 0; d < 3; d++) run_reset(d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined integer ALU for the execution stage, successor to the single-cycle combinational ALU. It adds configurable datapath width (XLEN 32/64) and pipeline depth, a valid/ready elastic handshake with bubble collapsing, and flush on misprediction. It extends the op set with Zbb min/max/count/extension ops. It sits between the issue/register-read stage and write-back and carries an opaque tag (ROB/graduation-list index) alongside each result.

## Interface
Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- STAGES, 2, number of pipeline register stages; legal 1..4; latency = STAGES cycles.
- TAG_W, 7, width of the opaque tag carried with each op.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  input op valid.
- ready_o  out  1  block can accept an op this cycle.
- op_i  in  5  opcode (see Operation).
- word_i  in  1  32-bit W-form; ignored when XLEN=32.
- uw_i  in  1  zero-extend rs1[31:0] before shift/add (.uw forms); ignored when XLEN=32.
- rs1_i, rs2_i  in  XLEN  operands.
- tag_i  in  TAG_W  tag.
- flush_i  in  1  kill all in-flight ops.
- valid_o  out  1  result valid at last stage.
- ready_i  in  1  downstream accepts result.
- result_o  out  XLEN  result.
- tag_o  out  TAG_W  tag of result.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 SLT, 6 SLTU, 7 AND, 8 OR, 9 XOR, 10 XNOR, 11 ANDN (rs1&~rs2), 12 ORN, 13 ROL, 14 ROR, 15 SH1ADD, 16 SH2ADD, 17 SH3ADD, 18 MIN, 19 MAX, 20 MINU, 21 MAXU, 22 CLZ, 23 CTZ, 24 CPOP, 25 SEXTB, 26 SEXTH, 27 ZEXTH. Opcodes 28-31 produce result 0.
- uw_i=1 (XLEN=64): rs1 operand replaced by {32'b0, rs1[31:0]} before SLL and ADD/SHnADD. Other ops ignore uw_i.
- word_i=1 (XLEN=64): applies to ADD, SUB, SLL, SRL, SRA, ROL, ROR, CLZ, CTZ, CPOP. The op runs on bits [31:0]; SRL/ROL/ROR/CLZ/CTZ/CPOP zero-extend the 32-bit input, SRA sign-extends it. The 32-bit result is sign-extended to 64. Other ops ignore word_i.
- Shift/rotate amount: rs2[log2(XLEN)-1:0]; rs2[4:0] in word mode.
- SHnADD: (rs1 << n) + rs2, truncated to XLEN. All add/sub wrap modulo 2^XLEN.
- CLZ/CTZ of zero = operand width (XLEN, or 32 in word mode). CPOP counts ones.
- Compute is combinational ahead of stage 0 register; stages 1..STAGES-1 are pure carry registers (valid, result, tag).
- Elastic pipeline: stage k advances when stage k+1 is empty or advancing; last stage advances when ready_i=1. ready_o = !valid[0] | advance[0]. Bubbles collapse.
- Accept: valid_i & ready_o loads stage 0.
- flush_i=1: all stage valid bits clear at the next edge; an op presented in the same cycle is dropped; valid_o may still be 1 during the flush cycle (downstream must ignore it).
- Data/tag registers do not reset; only valid bits reset.

## Timing
- Reset: all valid bits = 0; valid_o=0, ready_o=1 in the cycle after reset; result_o/tag_o undefined until first valid.
- Latency: op accepted at edge N appears with valid_o=1 after edge N+STAGES-1 (visible STAGES cycles after presentation). Throughput 1 op/cycle with ready_i held 1.
- Backpressure: with ready_i=0 and all STAGES stages full, ready_o=0 combinationally. valid_o, result_o and tag_o hold stable while valid_o=1 and ready_i=0.
- Full pipe, ready_i=1 with valid_i=1: ready_o=1 and one op is in and one out in the same cycle.
- rst_i dominates flush_i and valid_i.

## Test plan
- XLEN=64, STAGES=2, ADD rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> result 0 two cycles later, tag echoed.
- ADD word_i=1, rs1=0x7FFF_FFFF, rs2=1 -> 0xFFFF_FFFF_8000_0000. SRA word rs1=0x8000_0000, rs2=4 -> 0xFFFF_FFFF_F800_0000. SH2ADD uw rs1=0xFFFF_FFFF_0000_0001, rs2=2 -> 6.
- CLZ rs1=0 -> 64. CLZ word rs1=0x1 -> 31. CTZ rs1=0x100 -> 8. CPOP rs1=0xF0F0 -> 8. MIN(-1,1) -> -1. MINU(-1,1) -> 1. ROR rs1=1, rs2=1 -> 0x8000_0000_0000_0000.
- Backpressure: stream 5 ops, hold ready_i=0 for 4 cycles. Required: ready_o drops after 2 accepts, no op lost or duplicated, tags emerge in order.
- Flush: with 2 ops in flight plus one presented in the same cycle, assert flush_i. Required: valid_o=0 the next cycle, and the next accepted op emerges with correct latency.
- Reset mid-stream with a full pipe: valid_o=0 and ready_o=1 the cycle after reset. Repeat the regressions for XLEN=32 (word_i ignored) and STAGES=1, 4.
